// File: rtl/load_store_unit_if.sv
// Request, writeback and byte-bus signals between the scheduler/memory
// side and the load/store unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 16
) ();
  // scheduler -> LSU request
  logic              rq_start;
  logic              rq_cmd;
  logic              rq_width;
  logic              rq_tag;
  logic [ADDR_W-1:0] agu_addr;
  logic [15:0]       st_data;
  logic              rq_wait;
  // LSU -> writeback
  logic [15:0]       data_out;
  logic              data_tag;
  logic              data_wb;
  // LSU <-> 8-bit memory bus
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_dout;
  logic [7:0]        mem_din;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ready;

  // Environment side: scheduler front plus memory responder.
  modport master (
    output rq_start, rq_cmd, rq_width, rq_tag, agu_addr, st_data,
    output mem_din, mem_ready,
    input  rq_wait, data_out, data_tag, data_wb,
    input  mem_addr, mem_dout, mem_rd, mem_wr
  );

  // LSU side.
  modport slave (
    input  rq_start, rq_cmd, rq_width, rq_tag, agu_addr, st_data,
    input  mem_din, mem_ready,
    output rq_wait, data_out, data_tag, data_wb,
    output mem_addr, mem_dout, mem_rd, mem_wr
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes one scheduler request at a time and runs it as one
// or two byte cycles on the external 8-bit bus. Loads return on the
// writeback channel with the tag of the issuing reservation station.
module load_store_unit #(
  parameter int ADDR_W    = 16,
  parameter bit BYTE_SEXT = 1'b0
) (
  input  logic                 clk,
  input  logic                 a_rst,
  load_store_unit_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, WB} state_t;

  state_t            state_reg, state_next;
  logic              busy_reg;
  logic              cmd_reg, width_reg, tag_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_hi;
  logic [15:0]       st_data_reg;
  logic [7:0]        lo_reg;
  logic [15:0]       data_out_reg;
  logic              data_tag_reg;
  logic              data_wb_reg;
  logic [15:0]       byte_result;
  logic              lo_done, hi_done;

  // Second byte of a word access; natural wrap at the top of the space.
  assign addr_hi = addr_reg + ADDR_W'(1);

  assign lo_done = (state_reg == LO) && bus.mem_ready;
  assign hi_done = (state_reg == HI) && bus.mem_ready;

  // Byte-load result: low byte straight from the bus, upper byte either
  // zeros or copies of bit 7 depending on BYTE_SEXT.
  genvar gi;
  generate
    for (gi = 8; gi < 16; gi++) begin : g_ext
      assign byte_result[gi] = BYTE_SEXT & bus.mem_din[7];
    end
  endgenerate
  assign byte_result[7:0] = bus.mem_din;

  // State register; busy is registered so rq_wait never depends on rq_start.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  // Next state and bus drive; strobes decode from state so reset drops them at once.
  always_comb begin
    state_next   = state_reg;
    bus.mem_addr = '0;
    bus.mem_dout = '0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.rq_start) state_next = LO;
      end
      LO: begin
        bus.mem_addr = addr_reg;
        bus.mem_dout = st_data_reg[7:0];
        bus.mem_rd   = ~cmd_reg;
        bus.mem_wr   = cmd_reg;
        if (bus.mem_ready) begin
          if (width_reg)    state_next = HI;
          else if (cmd_reg) state_next = IDLE;
          else              state_next = WB;
        end
      end
      HI: begin
        bus.mem_addr = addr_hi;
        bus.mem_dout = st_data_reg[15:8];
        bus.mem_rd   = ~cmd_reg;
        bus.mem_wr   = cmd_reg;
        if (bus.mem_ready) begin
          if (cmd_reg) state_next = IDLE;
          else         state_next = WB;
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the request fields on acceptance so the scheduler may move on.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      cmd_reg     <= 1'b0;
      width_reg   <= 1'b0;
      tag_reg     <= 1'b0;
      addr_reg    <= '0;
      st_data_reg <= '0;
    end else if ((state_reg == IDLE) && bus.rq_start) begin
      cmd_reg     <= bus.rq_cmd;
      width_reg   <= bus.rq_width;
      tag_reg     <= bus.rq_tag;
      addr_reg    <= bus.agu_addr;
      st_data_reg <= bus.st_data;
    end
  end

  // Hold the low byte of a word load until the high byte arrives.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      lo_reg <= '0;
    end else if (lo_done) begin
      lo_reg <= bus.mem_din;
    end
  end

  // Build the load result on the edge into WB; it then holds until the next load.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      data_out_reg <= '0;
      data_tag_reg <= 1'b0;
      data_wb_reg  <= 1'b0;
    end else begin
      data_wb_reg <= (state_next == WB);
      if (lo_done && !width_reg && !cmd_reg) begin
        data_out_reg <= byte_result;
        data_tag_reg <= tag_reg;
      end else if (hi_done && !cmd_reg) begin
        data_out_reg <= {bus.mem_din, lo_reg};
        data_tag_reg <= tag_reg;
      end
    end
  end

  assign bus.rq_wait  = busy_reg;
  assign bus.data_out = data_out_reg;
  assign bus.data_tag = data_tag_reg;
  assign bus.data_wb  = data_wb_reg;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Responder end of the scheduler→LSU request interface. Accepts one memory request at a time and runs it as one or two byte cycles on the 8-bit external memory bus. Load data is returned on the LSU writeback channel, carrying the reservation-station tag the request arrived with. Back-pressures the scheduler through rq_wait while busy.

Parameters:
ADDR_W, 16, address width of agu_addr and mem_addr
BYTE_SEXT, 0, 1 = sign-extend byte loads to 16 bits, 0 = zero-extend

Ports:
clk  in  1  single clock, all state on rising edge
a_rst  in  1  asynchronous, active-high reset
rq_start  in  1  request valid (scheduler front: load or store)
rq_cmd  in  1  1 = store, 0 = load
rq_width  in  1  1 = 16-bit access, 0 = 8-bit access
rq_tag  in  1  station tag (0 = rsa, 1 = rsb), echoed on data_tag
agu_addr  in  ADDR_W  effective address from AGU
st_data  in  16  store data (low byte used for 8-bit stores)
rq_wait  out  1  LSU busy; scheduler holds its front stage while high
data_out  out  16  load result
data_tag  out  1  tag of the returning load
data_wb  out  1  one-cycle strobe: data_out/data_tag valid for writeback
mem_addr  out  ADDR_W  bus address
mem_dout  out  8  bus write data
mem_din  in  8  bus read data
mem_rd  out  1  bus read strobe
mem_wr  out  1  bus write strobe
mem_ready  in  1  bus cycle completes this clock

Behaviour:
- Reset: state IDLE. rq_wait=0, data_wb=0, data_out=0, data_tag=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_dout=0. Reset mid-operation abandons the access: strobes drop immediately (asynchronously), no writeback is issued.
- Handshake: a request is accepted in IDLE when rq_start=1. On acceptance, register cmd, width, tag, addr and st_data. rq_wait = (state != IDLE), driven from a register with no combinational path from rq_start. rq_start while busy is ignored; the scheduler holds the request because rq_wait=1. At most one request is outstanding.
- States: IDLE, LO, HI, WB.
- LO: mem_addr = addr, mem_rd = ~cmd, mem_wr = cmd, mem_dout = st_data[7:0]. Strobes stay asserted until mem_ready. On mem_ready, capture mem_din into the low byte. Next state: width=1 → HI; width=0 and load → WB; width=0 and store → IDLE.
- HI: mem_addr = addr+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000), mem_dout = st_data[15:8]. Same strobes as LO. On mem_ready, capture mem_din into the high byte. Load → WB, store → IDLE.
- WB: data_wb=1 for exactly one cycle with data_out and data_tag valid. Next state IDLE.
- data_out for a byte load: {8{BYTE_SEXT & lo[7]}, lo}. For a word load: little-endian {hi, lo}. data_out and data_tag hold their values after WB until the next WB.
- Stores never assert data_wb.
- Latency with mem_ready tied high, acceptance at cycle 0:
  - byte load: LO@1, WB@2 (data_wb), accept next @3.
  - word load: WB@3.
  - byte store: done @1, accept next @2.
  - word store: accept next @3.
  - Each cycle of mem_ready=0 adds one cycle in the current state.
- mem_rd and mem_wr are never both 1. Both are 0 in IDLE and WB.

Test Plan:
- Reset mid word load (a_rst pulsed while in HI) → strobes 0 immediately; after release state IDLE, rq_wait=0, and no data_wb pulse follows.
- Byte load, tag 1, addr 0x1234, mem_din=0x9A, mem_ready=1, BYTE_SEXT=0 → mem_rd@1 with addr 0x1234; data_wb@2 with data_out=0x009A, data_tag=1. With BYTE_SEXT=1 → data_out=0xFF9A.
- Word load at addr 0xFFFF, mem returns 0x34 then 0x12 → bus addresses 0xFFFF then 0x0000; data_out=0x1234, data_tag=0.
- Word store 0xBEEF at 0x0200 with mem_ready low 2 cycles per access → writes 0xEF@0x0200 then 0xBE@0x0201, each strobe held 3 cycles; rq_wait high throughout; no data_wb.
- Back-to-back requests, second rq_start held high during busy → second request accepted only on the first cycle rq_wait=0; exactly one bus transaction sequence per request.
